// File: rtl/anita3_deadtime_pkg.sv
// anita3_deadtime_pkg: shared widths, readout word layout and read-FSM encodings.
package anita3_deadtime_pkg;
    localparam int DT_WIDTH   = 16;
    localparam int DROP_WIDTH = 8;
    localparam int TAG_MSB    = 31;
    localparam int TAG_LSB    = 16;
    localparam int DT_MSB     = 15;
    localparam int DT_LSB     = 0;

    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, ACK = 2'd2} rd_state_t;

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction
endpackage

// File: rtl/anita3_sync_fifo.sv
// anita3_sync_fifo: single-clock circular buffer with push/pop/flush and occupancy flags.
module anita3_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  empty,
    output logic                  full
);
    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                wr_en, rd_en;

    // a push into a full buffer still fits when the head leaves in the same cycle
    assign rd_en   = pop & ~empty;
    assign wr_en   = push & (~full | rd_en);
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign fill    = wr_ptr - rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
endmodule

// File: rtl/anita3_deadtime_readout.sv
// anita3_deadtime_readout: per-PPS deadtime capture, second tagging, FIFO buffering and req/ack readout.
// Optional DEADTIME_READOUT_LATEST_EN adds latest_o, the most recent captured deadtime.
module anita3_deadtime_readout
    import anita3_deadtime_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                          clk33_i,
    input  logic                          rst_n_i,
    input  logic                          pps_clk33_i,
    input  logic [DT_WIDTH-1:0]           deadtime_i,
    input  logic                          clear_i,
`ifdef DEADTIME_READOUT_LATEST_EN
    output logic [DT_WIDTH-1:0]           latest_o,
`endif
    input  logic                          rd_req_i,
    output logic                          rd_ack_o,
    output logic                          rd_valid_o,
    output logic [TAG_WIDTH+DT_WIDTH-1:0] rd_data_o,
    output logic [DEPTH_LOG2:0]           fill_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic [DROP_WIDTH-1:0]         drop_cnt_o
);
    rd_state_t                    state;
    logic                         pps_d, pop, drop;
    logic [TAG_WIDTH-1:0]         tag;
    logic [TAG_WIDTH+DT_WIDTH-1:0] head;

    assign pop  = (state == POP) & ~empty_o;
    assign drop = pps_d & ~clear_i & full_o & ~pop;

    anita3_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(TAG_WIDTH+DT_WIDTH)) u_fifo (
        .clk     (clk33_i),
        .rst_n   (rst_n_i),
        .push    (pps_d),
        .pop     (pop),
        .flush   (clear_i),
        .wr_data ({tag, deadtime_i}),
        .rd_data (head),
        .fill    (fill_o),
        .empty   (empty_o),
        .full    (full_o)
    );

    // the tag counts seconds, so it advances on every PPS whether or not the word was kept
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pps_d      <= 1'b0;
            tag        <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            pps_d <= pps_clk33_i;
            if (pps_d) tag <= tag + TAG_WIDTH'(1);
            if (clear_i) begin
                overflow_o <= 1'b0;
                drop_cnt_o <= '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= sat_inc(drop_cnt_o);
            end
        end
    end

`ifdef DEADTIME_READOUT_LATEST_EN
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) latest_o <= '0;
        else if (pps_d) latest_o <= deadtime_i;
    end
`endif

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            rd_ack_o   <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            case (state)
                IDLE: if (rd_req_i) state <= POP;
                POP: begin
                    state      <= ACK;
                    rd_ack_o   <= 1'b1;
                    rd_valid_o <= ~empty_o;
                    rd_data_o  <= empty_o ? '0 : head;
                end
                default: begin
                    state    <= IDLE;
                    rd_ack_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_anita3_deadtime_readout.sv
// tb_anita3_deadtime_readout: directed stimulus with a queue model of the FIFO and tag counter.
module tb_anita3_deadtime_readout;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps = 1'b0;
    logic [15:0] deadtime = '0;
    logic        clear = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_ack, rd_valid, empty, full, overflow;
    logic [31:0] rd_data;
    logic [4:0]  fill;
    logic [7:0]  drop_cnt;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model[$];
    logic [15:0] m_tag = '0;
    logic [7:0]  m_drop = '0;

    always #5 clk = ~clk;

    anita3_deadtime_readout dut (
        .clk33_i     (clk),
        .rst_n_i     (rst_n),
        .pps_clk33_i (pps),
        .deadtime_i  (deadtime),
        .clear_i     (clear),
        .rd_req_i    (rd_req),
        .rd_ack_o    (rd_ack),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .fill_o      (fill),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        model.delete();
        m_tag  = '0;
        m_drop = '0;
    endtask

    task automatic do_pps(input logic [15:0] dt);
        deadtime = dt;
        pps = 1'b1;
        tick();
        pps = 1'b0;
        tick();
        if (model.size() < 16) model.push_back({m_tag, dt});
        else m_drop = (m_drop == 8'hFF) ? m_drop : m_drop + 8'd1;
        m_tag++;
    endtask

    task automatic do_read(input string name);
        logic [31:0] exp_d;
        logic        exp_v;
        exp_v = model.size() > 0;
        exp_d = exp_v ? model.pop_front() : 32'h0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({name, "_early_ack"}, rd_ack, 0);
        tick();
        check({name, "_ack"}, rd_ack, 1);
        check({name, "_valid"}, rd_valid, exp_v);
        check({name, "_data"}, rd_data, exp_d);
        tick();
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_ack"}, rd_ack, 0);
        check({name, "_valid"}, rd_valid, 0);
        check({name, "_data"}, rd_data, 0);
        check({name, "_fill"}, fill, 0);
        check({name, "_empty"}, empty, 1);
        check({name, "_full"}, full, 0);
        check({name, "_ovf"}, overflow, 0);
        check({name, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        logic [31:0] exp_d;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // 1: three captures then three reads
        do_pps(16'h0010);
        do_pps(16'h0020);
        do_pps(16'h0030);
        check("t1_fill", fill, 3);
        check("t1_head", model[0], 32'h0000_0010);
        do_read("t1_r0");
        do_read("t1_r1");
        do_read("t1_r2");
        check("t1_empty", empty, 1);

        // 2: read while empty
        do_read("t2_empty_read");

        // 3: overrun from tag 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 20; i++) do_pps(16'h0100 + 16'(i));
        check("t3_full", full, 1);
        check("t3_fill", fill, 16);
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 8'd4);
        check("t3_drop_model", drop_cnt, m_drop);
        check("t3_last_tag", model[15][31:16], 16'h000F);

        // 4: capture and pop in the same cycle while full
        exp_d = model.pop_front();
        deadtime = 16'h0AAA;
        pps = 1'b1;
        rd_req = 1'b1;
        tick();
        pps = 1'b0;
        rd_req = 1'b0;
        check("t4_pop_fill", fill, 16);
        tick();
        model.push_back({m_tag, 16'h0AAA});
        m_tag++;
        check("t4_ack", rd_ack, 1);
        check("t4_head_tag", rd_data[31:16], 16'h0000);
        check("t4_data", rd_data, exp_d);
        check("t4_fill", fill, 16);
        check("t4_drop", drop_cnt, 8'd4);
        tick();
        for (int i = 0; i < 11; i++) do_read("t4_drain");
        check("t5_pre_fill", fill, 5);
        check("t5_pre_ovf", overflow, 1);

        // 5: clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model.delete();
        m_drop = '0;
        check("t5_fill", fill, 0);
        check("t5_ovf", overflow, 0);
        check("t5_drop", drop_cnt, 0);
        check("t5_empty", empty, 1);
        do_pps(16'h0555);
        check("t5_tag", model[0][31:16], 16'h0015);
        do_read("t5_after_clear");

        // 6a: reset while the ack is pending
        do_pps(16'h0066);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_state("t6_rst");
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check("t6_no_ack0", rd_ack, 0);
        tick();
        check("t6_no_ack1", rd_ack, 0);

        // 6b: request during POP is ignored
        do_pps(16'h0077);
        rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        exp_d = model.pop_front();
        check("t6b_ack", rd_ack, 1);
        check("t6b_data", rd_data, exp_d);
        tick();
        check("t6b_ack_low", rd_ack, 0);
        tick();
        check("t6b_no_ack0", rd_ack, 0);
        tick();
        check("t6b_no_ack1", rd_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
